// File: rtl/add_pipe_acc.sv
// Pipelined unsigned adder with valid/ready flow control, wrap/saturate overflow
// and an optional running accumulator applied at the final stage.
module add_pipe_acc #(
    parameter int WIDTH  = 14,
    parameter int STAGES = 2,
    parameter int SAT    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             acc_en,
    input  logic             clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_1,
    output logic             ovf
);

    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  acc;

    logic [WIDTH:0]    fin_psum;
    logic              fin_acc_en;
    logic              fin_src_v;
    logic              fin_load;
    logic [WIDTH-1:0]  base;
    logic [WIDTH+1:0]  total;
    logic              fin_ovf;
    logic [WIDTH-1:0]  fin_res;

    // A stage can advance when it or any stage downstream of it has a hole,
    // or when the consumer drains the last stage this edge.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready || !(&vld_pipe[STAGES-1:k]);
    end

    assign in_ready  = rst_n && adv[0];
    assign out_valid = vld_pipe[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            if (adv[0]) vld_pipe[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                if (adv[k]) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    if (STAGES == 1) begin : g_one
        assign fin_psum   = {1'b0, in_1} + {1'b0, in_2};
        assign fin_acc_en = acc_en;
        assign fin_src_v  = in_valid;
    end else begin : g_multi
        logic [STAGES-2:0][WIDTH:0] psum_q;
        logic [STAGES-2:0]          acc_en_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                psum_q   <= '0;
                acc_en_q <= '0;
            end else begin
                if (adv[0]) begin
                    psum_q[0]   <= {1'b0, in_1} + {1'b0, in_2};
                    acc_en_q[0] <= acc_en;
                end
                for (int k = 1; k < STAGES-1; k++)
                    if (adv[k]) begin
                        psum_q[k]   <= psum_q[k-1];
                        acc_en_q[k] <= acc_en_q[k-1];
                    end
            end
        end

        assign fin_psum   = psum_q[STAGES-2];
        assign fin_acc_en = acc_en_q[STAGES-2];
        assign fin_src_v  = vld_pipe[STAGES-2];
    end

    // clr wins over the accumulator contents for a coincident accumulate beat.
    always_comb begin
        base    = clr ? '0 : acc;
        total   = fin_acc_en ? ({1'b0, fin_psum} + {2'b0, base}) : {1'b0, fin_psum};
        fin_ovf = |total[WIDTH+1:WIDTH];
        fin_res = ((SAT != 0) && fin_ovf) ? '1 : total[WIDTH-1:0];
    end

    assign fin_load = fin_src_v && adv[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_1 <= '0;
            ovf   <= 1'b0;
            acc   <= '0;
        end else begin
            if (fin_load) begin
                out_1 <= fin_res;
                ovf   <= fin_ovf;
            end
            if (fin_load && fin_acc_en) acc <= fin_res;
            else if (clr)               acc <= '0;
        end
    end

endmodule

// File: tb/tb_add_pipe_acc.sv
// Directed bench for add_pipe_acc: reset, streaming, overflow (wrap and saturate),
// backpressure, accumulate with clear, and asynchronous reset mid-stream.
module tb_add_pipe_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_ready_s;
    logic [13:0] in_1, in_2;
    logic        acc_en, clr;
    logic        out_valid, out_valid_s, out_ready;
    logic [13:0] out_1, out_1_s;
    logic        ovf, ovf_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    add_pipe_acc #(.WIDTH(14), .STAGES(2), .SAT(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_1(in_1), .in_2(in_2), .acc_en(acc_en), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_1(out_1), .ovf(ovf)
    );

    add_pipe_acc #(.WIDTH(14), .STAGES(2), .SAT(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_1(in_1), .in_2(in_2), .acc_en(acc_en), .clr(clr),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_1(out_1_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [13:0] a, input logic [13:0] b, input logic ae);
        in_valid = 1'b1;
        in_1     = a;
        in_2     = b;
        acc_en   = ae;
    endtask

    initial begin
        int          k;
        logic        take;
        logic [13:0] got[$];

        rst_n = 1'b0; in_valid = 1'b1; in_1 = 14'd5; in_2 = 14'd5;
        acc_en = 1'b0; clr = 1'b0; out_ready = 1'b1;

        // reset held with input offered
        tick(); tick();
        chk("rst_in_ready",   32'(in_ready), 32'd0);
        chk("rst_in_ready_s", 32'(in_ready_s), 32'd0);
        chk("rst_out_valid",  32'(out_valid), 32'd0);
        chk("rst_out_1",      32'(out_1), 32'd0);
        chk("rst_ovf",        32'(ovf), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // back-to-back streaming
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(14'(i), 14'(i + 1), 1'b0);
            tick();
            if (i > 0) begin
                chk("strm_valid", 32'(out_valid), 32'd1);
                chk("strm_out",   32'(out_1), 32'(2 * i - 1));
                chk("strm_ovf",   32'(ovf), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        chk("strm_valid_last", 32'(out_valid), 32'd1);
        chk("strm_out_last",   32'(out_1), 32'h7);
        tick();
        chk("strm_drained", 32'(out_valid), 32'd0);

        // overflow: wrap vs saturate, then the largest non-overflowing sum
        drive(14'h3FFF, 14'h0001, 1'b0);
        tick();
        drive(14'h2000, 14'h1FFF, 1'b0);
        tick();
        chk("ovf_wrap_out",  32'(out_1), 32'h0000);
        chk("ovf_wrap_flag", 32'(ovf), 32'd1);
        chk("ovf_sat_valid", 32'(out_valid_s), 32'd1);
        chk("ovf_sat_out",   32'(out_1_s), 32'h3FFF);
        chk("ovf_sat_flag",  32'(ovf_s), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("edge_wrap_out",  32'(out_1), 32'h3FFF);
        chk("edge_wrap_flag", 32'(ovf), 32'd0);
        chk("edge_sat_out",   32'(out_1_s), 32'h3FFF);
        chk("edge_sat_flag",  32'(ovf_s), 32'd0);
        tick();

        // backpressure: only STAGES beats fit while the consumer stalls
        out_ready = 1'b0;
        k = 0;
        drive(14'h100, 14'd0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            take = in_valid && in_ready;
            tick();
            if (take) begin
                k++;
                drive(14'((k + 1) * 256), 14'(k), 1'b0);
            end
            if (c >= 2) chk("bp_hold_out", 32'(out_1), 32'h100);
        end
        chk("bp_accepted",  32'(k), 32'd2);
        chk("bp_in_ready",  32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && got.size() < 4; c++) begin
            @(negedge clk);
            if (out_valid) got.push_back(out_1);
            take = in_valid && in_ready;
            tick();
            if (take) begin
                k++;
                if (k < 4) drive(14'((k + 1) * 256), 14'(k), 1'b0);
                else       in_valid = 1'b0;
            end
        end
        chk("bp_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("bp_order", (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'((i + 1) * 256 + i));
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // accumulate
        clr = 1'b1; tick(); clr = 1'b0;
        drive(14'd10, 14'd5, 1'b1);
        tick();
        drive(14'd100, 14'd0, 1'b1);
        tick();
        chk("acc_15", 32'(out_1), 32'd15);
        drive(14'd1, 14'd1, 1'b1);
        tick();
        chk("acc_115", 32'(out_1), 32'd115);
        in_valid = 1'b0;
        tick();
        chk("acc_117", 32'(out_1), 32'd117);
        tick();
        drive(14'd2, 14'd3, 1'b1);
        tick();
        in_valid = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("acc_clr_coinc", 32'(out_1), 32'd5);
        drive(14'd7, 14'd7, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("acc_noacc", 32'(out_1), 32'd14);
        tick();
        drive(14'd0, 14'd0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("acc_kept", 32'(out_1), 32'd5);
        tick();

        // async reset with two beats in flight
        drive(14'd9, 14'd9, 1'b1);
        tick();
        drive(14'd1, 14'd0, 1'b1);
        tick();
        chk("mid_pre_out", 32'(out_1), 32'd23);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_1",     32'(out_1), 32'd0);
        chk("mid_in_ready",  32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(in_ready), 32'd1);
        tick(); tick();
        chk("mid_no_stale", 32'(out_valid), 32'd0);
        drive(14'd3, 14'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_acc_zero", 32'(out_1), 32'd7);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/add_pipe_acc.md
Name: add_pipe_acc

Overview:
- Parametrised, pipelined successor to the team's combinational 14-bit adder.
- Adds two unsigned operands in_1 and in_2 through a valid/ready pipeline of configurable depth.
- Overflow can wrap or saturate, and an optional per-beat running accumulator is available.
- Sits between a producer and a consumer stream in the datapath; full throughput of one beat per clock when not back-pressured.

Parameters:
- WIDTH, 14, operand/result width in bits (2..32).
- STAGES, 2, pipeline depth in register stages (1..4); equals latency in cycles.
- SAT, 0, overflow mode: 0 = wrap (modulo 2^WIDTH), 1 = saturate to 2^WIDTH-1.

Ports:
- clk  input  1  Single clock; all logic on rising edge.
- rst_n  input  1  Asynchronous active-low reset.
- in_valid  input  1  Input beat present.
- in_ready  output  1  Block can accept an input beat.
- in_1  input  WIDTH  Operand A, unsigned.
- in_2  input  WIDTH  Operand B, unsigned.
- acc_en  input  1  Sampled with the input beat; add this beat into the accumulator.
- clr  input  1  Synchronous accumulator clear; independent of handshake.
- out_valid  output  1  Result beat present.
- out_ready  input  1  Consumer accepts the result.
- out_1  output  WIDTH  Result.
- ovf  output  1  Result overflowed 2^WIDTH-1; qualified by out_valid.

Behaviour:
- Reset:
  - rst_n low asynchronously clears all stage valid bits, out_valid, out_1, ovf and acc to 0.
  - in_ready is 0 while rst_n is low.
  - Beats in flight are discarded; there is no partial output.
- Handshake:
  - A transfer occurs on any edge where valid and ready are both 1.
  - in_ready = !v[0] || adv[0], where adv[k] is 1 when stage k is empty or its contents move on this edge.
  - The last stage advances when out_ready is 1 or it is empty.
  - The ready chain is combinational through all stages.
  - out_valid = v[STAGES-1]; out_1 and ovf are registered and held stable while out_valid=1 and out_ready=0.
  - in_ready does not depend on in_valid.
- Stage 1 (first load):
  - psum = in_1 + in_2, computed WIDTH+1 bits wide.
  - The stage stores psum together with the acc_en flag.
- Intermediate stages: pure delay registers gated by adv.
- Final-stage load (the stage-1 load when STAGES=1):
  - base = clr ? 0 : acc.
  - total = acc_en ? (base + psum) : psum, computed WIDTH+2 bits wide.
  - ovf = |total[WIDTH+1:WIDTH].
  - out_1 = SAT ? (ovf ? all-ones : total[WIDTH-1:0]) : total[WIDTH-1:0].
  - If acc_en, acc <= out_1 value (the saturated or wrapped result).
  - If not acc_en, acc <= clr ? 0 : acc.
- clr:
  - Clears acc on any edge it is high, regardless of handshake.
  - When coincident with an acc_en beat loading the final stage, the clear takes effect first (base = 0).
- Latency and ordering:
  - A beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1 (visible in cycle N+STAGES) when there are no stalls.
  - Results are strictly in order; no duplication or loss under any out_ready pattern.
- Capacity:
  - Exactly STAGES beats can be held while out_ready=0; in_ready then drops to 0.
  - With a full pipe and out_ready=1, accepting an input and emitting an output on the same edge is allowed.
- Reset mid-operation: behaves as the reset above; after release, in_ready=1 on the first cycle.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, out_valid=0, out_1=0, ovf=0; release -> in_ready=1.
- Streaming (WIDTH=14, STAGES=2, out_ready=1): pairs (0,1),(1,2),(2,3),(3,4) back-to-back -> out_1 = 0x0001, 0x0003, 0x0005, 0x0007 on four consecutive cycles, the first 2 cycles after the first accept; ovf=0.
- Overflow (0x3FFF, 0x0001):
  - SAT=0 -> out_1=0x0000, ovf=1.
  - SAT=1 -> out_1=0x3FFF, ovf=1.
  - (0x2000, 0x1FFF) -> out_1=0x3FFF, ovf=0.
- Backpressure: out_ready=0 for 6 cycles while offering 4 beats -> exactly 2 accepted, in_ready=0, out_1 stable; raise out_ready -> all 4 results emerge in order, none lost or repeated.
- Accumulate:
  - Pulse clr, then acc_en beats (10,5),(100,0),(1,1) -> 15, 115, 117.
  - Then clr coincident with the final-stage load of acc_en beat (2,3) -> 5.
  - Then non-acc beat (7,7) -> 14, with acc still 5.
- Async reset mid-stream: assert rst_n=0 between edges with 2 beats in flight -> out_valid falls immediately, acc=0, no stale beat after release.
